// File: rtl/m_axi_rd_burst.sv
// AXI4 read master: splits one user request into INCR bursts (<= MAX_BURST beats, no 4 KB
// crossing), one burst outstanding, with a zero-latency valid/ready pass-through of read data.
module m_axi_rd_burst #(
  parameter int ID_W      = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_beats,
  output logic              rd_busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic              rd_last,
  output logic              rd_done,
  output logic              rd_err,
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arlock,
  output logic [3:0]        axi_arcache,
  output logic [2:0]        axi_arprot,
  output logic [3:0]        axi_arqos,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  localparam int SZ = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SZ) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [8:0]          blen_q, blen_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;

  logic                r_hs;
  logic                last_beat;
  logic [31:0]         lim_4k;
  logic [31:0]         blen_full;
  logic [8:0]          blen_calc;
  logic                unused_ok;

  assign r_hs      = (state_q == S_DATA) && axi_rvalid && rd_rdy;
  assign last_beat = (beat_q == arlen_q);
  assign unused_ok = ^axi_rid;

  // Burst length: smallest of remaining beats, MAX_BURST and beats left in this 4 KB page.
  always_comb begin
    lim_4k    = 32'((13'h1000 - {1'b0, addr_q[11:0]}) >> SZ);
    blen_full = (32'(rem_q) < 32'(MAX_BURST)) ? 32'(rem_q) : 32'(MAX_BURST);
    if (lim_4k < blen_full) begin
      blen_full = lim_4k;
    end
    blen_calc = 9'(blen_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      arlen_q <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      arlen_q <= arlen_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    arlen_d = arlen_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          addr_d  = rd_addr & ~ALIGN_MASK;
          rem_d   = rd_beats;
          err_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // A zero-length request passes through here so rd_done lands two cycles after start.
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          blen_d  = blen_calc;
          arlen_d = 8'(blen_calc - 9'd1);
          beat_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi_arready) begin
          addr_d  = addr_q + (ADDR_W'(blen_q) << SZ);
          rem_d   = rem_q - CNT_W'(blen_q);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 8'd1;
          if ((axi_rresp != 2'b00) || (axi_rlast != last_beat)) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = (rem_q == '0) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    axi_arvalid = (state_q == S_ADDR);
    axi_rready  = (state_q == S_DATA) && rd_rdy;
    rd_vld      = (state_q == S_DATA) && axi_rvalid;
    rd_last     = rd_vld && last_beat && (rem_q == '0);
    rd_done     = (state_q == S_DONE);
    rd_busy     = (state_q != S_IDLE);
  end

  assign rd_err      = err_q;
  assign rd_data     = axi_rdata;
  assign axi_arid    = '0;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = 3'(SZ);
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0010;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;

endmodule
